// File: rtl/dm_sba_lane.sv
// System-bus-access master for the debug module: size/alignment checks, byte-lane steering,
// autoincrement and a programmable stall timeout, for 32/64/128-bit buses.
module dm_sba_lane #(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmactive_i,
  output logic                  master_req_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbautoincrement_i,
  input  logic                  sbreadondata_i,
  input  logic [2:0]            sbaccess_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_read_valid_i,
  input  logic                  sbdata_write_valid_i,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o
);

  localparam int unsigned BeW  = BusWidth / 8;
  localparam int unsigned OffW = $clog2(BeW);

  typedef enum logic [2:0] {StIdle, StRead, StWaitR, StWrite, StWaitW} state_e;

  state_e              state_q;
  logic [BusWidth-1:0] addr_q, wdata_q, rdata_q;
  logic [2:0]          size_q;
  logic [31:0]         cnt_q;
  logic                rvalid_q, err_valid_q;
  logic [2:0]          err_q;

  logic [OffW-1:0]     off;
  logic                launch_rd, launch_wr, launch_go;
  logic                size_err, align_err, launch_err, timeout_hit;
  logic [BusWidth-1:0] launch_addr, align_mask, addr_incr;
  logic [BusWidth-1:0] wdata_shift, rdata_shift, rdata_mask;
  logic [BeW-1:0]      be_mask;

  assign off = addr_q[OffW-1:0];

  // Address write takes precedence over sbdata-triggered transfers.
  always_comb begin
    launch_addr = addr_q;
    launch_rd   = 1'b0;
    launch_wr   = 1'b0;
    if (sbaddress_write_valid_i) begin
      launch_addr = sbaddress_i;
      launch_rd   = sbreadonaddr_i;
    end else if (sbdata_read_valid_i && sbreadondata_i) begin
      launch_rd = 1'b1;
    end else if (sbdata_write_valid_i) begin
      launch_wr = 1'b1;
    end
  end

  assign launch_go   = launch_rd | launch_wr;
  assign align_mask  = (BusWidth'(1) << sbaccess_i) - BusWidth'(1);
  assign size_err    = 32'(sbaccess_i) > OffW;
  assign align_err   = |(launch_addr & align_mask);
  assign launch_err  = size_err | align_err;
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == TimeoutCycles - 1);
  assign addr_incr   = addr_q + (BusWidth'(1) << size_q);

  assign wdata_shift = wdata_q << {off, 3'b000};
  assign rdata_shift = master_r_rdata_i >> {off, 3'b000};

  always_comb begin
    be_mask    = '0;
    rdata_mask = '0;
    for (int i = 0; i < int'(BeW); i++) begin
      be_mask[i] = (i >= int'(off)) && (i < int'(off) + (1 << size_q));
      rdata_mask[8*i +: 8] = (i < (1 << size_q)) ? rdata_shift[8*i +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      rvalid_q    <= 1'b0;
      err_valid_q <= 1'b0;
      err_q       <= '0;
    end else if (!dmactive_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wdata_q     <= '0;
      rvalid_q    <= 1'b0;
      err_valid_q <= 1'b0;
    end else begin
      rvalid_q    <= 1'b0;
      err_valid_q <= 1'b0;
      if (state_q != StIdle) cnt_q <= cnt_q + 32'd1;
      if (state_q != StIdle && timeout_hit) begin
        state_q     <= StIdle;
        err_valid_q <= 1'b1;
        err_q       <= 3'd1;
      end else begin
        unique case (state_q)
          StIdle: begin
            // A failed read-on-address launch leaves the address register untouched.
            if (sbaddress_write_valid_i && !(launch_rd && launch_err)) addr_q <= sbaddress_i;
            if (launch_wr) wdata_q <= sbdata_i;
            if (launch_go) begin
              if (size_err) begin
                err_valid_q <= 1'b1;
                err_q       <= 3'd4;
              end else if (align_err) begin
                err_valid_q <= 1'b1;
                err_q       <= 3'd3;
              end else begin
                state_q <= launch_rd ? StRead : StWrite;
                size_q  <= sbaccess_i;
                cnt_q   <= '0;
              end
            end
          end
          StRead:  if (master_gnt_i) state_q <= StWaitR;
          StWrite: if (master_gnt_i) state_q <= StWaitW;
          StWaitR: begin
            if (master_r_valid_i) begin
              rdata_q  <= rdata_mask;
              rvalid_q <= 1'b1;
              state_q  <= StIdle;
              if (sbautoincrement_i) addr_q <= addr_incr;
            end
          end
          StWaitW: begin
            if (master_r_valid_i) begin
              state_q <= StIdle;
              if (sbautoincrement_i) addr_q <= addr_incr;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sbbusy_o        = state_q != StIdle;
  assign master_req_o    = (state_q == StRead) || (state_q == StWrite);
  assign master_we_o     = state_q == StWrite;
  assign master_be_o     = master_req_o ? be_mask : '0;
  assign master_wdata_o  = master_we_o ? wdata_shift : '0;
  assign master_add_o    = addr_q;
  assign sbaddress_o     = addr_q;
  assign sbdata_o        = rdata_q;
  assign sbdata_valid_o  = rvalid_q;
  assign sberror_valid_o = err_valid_q;
  assign sberror_o       = err_q;

endmodule

// File: tb/tb_dm_sba_lane.sv
// Directed bench for dm_sba_lane: 64-bit instance with an 8-cycle timeout and a 128-bit
// instance with the timeout disabled.
module tb_dm_sba_lane;

  logic clk = 1'b0;
  logic rst, dmactive;
  logic readonaddr, autoinc, readondata;
  logic [2:0] sbaccess;

  // 64-bit instance
  logic        req, we, gnt, r_valid, addr_wv, data_rv, data_wv;
  logic        sbdata_valid, busy, errv;
  logic [2:0]  err;
  logic [7:0]  be;
  logic [63:0] add, wdata, rdata, sbaddress, addr_o, sbdata_in, sbdata;

  // 128-bit instance
  logic         w_req, w_we, w_gnt, w_r_valid, w_addr_wv, w_data_rv, w_data_wv;
  logic         w_sbdata_valid, w_busy, w_errv;
  logic [2:0]   w_err;
  logic [15:0]  w_be;
  logic [127:0] w_add, w_wdata, w_rdata, w_sbaddress, w_addr_o, w_sbdata_in, w_sbdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_sba_lane #(.BusWidth(64), .TimeoutCycles(8)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive),
    .master_req_o(req), .master_add_o(add), .master_we_o(we), .master_wdata_o(wdata),
    .master_be_o(be), .master_gnt_i(gnt), .master_r_valid_i(r_valid),
    .master_r_rdata_i(rdata), .sbaddress_i(sbaddress), .sbaddress_o(addr_o),
    .sbaddress_write_valid_i(addr_wv), .sbreadonaddr_i(readonaddr),
    .sbautoincrement_i(autoinc), .sbreadondata_i(readondata), .sbaccess_i(sbaccess),
    .sbdata_i(sbdata_in), .sbdata_read_valid_i(data_rv), .sbdata_write_valid_i(data_wv),
    .sbdata_o(sbdata), .sbdata_valid_o(sbdata_valid), .sbbusy_o(busy),
    .sberror_valid_o(errv), .sberror_o(err)
  );

  dm_sba_lane #(.BusWidth(128), .TimeoutCycles(0)) u_dut128 (
    .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive),
    .master_req_o(w_req), .master_add_o(w_add), .master_we_o(w_we),
    .master_wdata_o(w_wdata), .master_be_o(w_be), .master_gnt_i(w_gnt),
    .master_r_valid_i(w_r_valid), .master_r_rdata_i(w_rdata), .sbaddress_i(w_sbaddress),
    .sbaddress_o(w_addr_o), .sbaddress_write_valid_i(w_addr_wv),
    .sbreadonaddr_i(readonaddr), .sbautoincrement_i(autoinc), .sbreadondata_i(readondata),
    .sbaccess_i(sbaccess), .sbdata_i(w_sbdata_in), .sbdata_read_valid_i(w_data_rv),
    .sbdata_write_valid_i(w_data_wv), .sbdata_o(w_sbdata), .sbdata_valid_o(w_sbdata_valid),
    .sbbusy_o(w_busy), .sberror_valid_o(w_errv), .sberror_o(w_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; dmactive = 1'b1;
    readonaddr = 1'b0; autoinc = 1'b0; readondata = 1'b0; sbaccess = 3'd0;
    gnt = 1'b0; r_valid = 1'b0; addr_wv = 1'b0; data_rv = 1'b0; data_wv = 1'b0;
    rdata = '0; sbaddress = '0; sbdata_in = '0;
    w_gnt = 1'b0; w_r_valid = 1'b0; w_addr_wv = 1'b0; w_data_rv = 1'b0; w_data_wv = 1'b0;
    w_rdata = '0; w_sbaddress = '0; w_sbdata_in = '0;
    #2 rst = 1'b1;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_req", req, 0);
    check("rst_addr", addr_o, 0);
    check("rst_be", be, 0);
    check("rst_sbdata", sbdata, 0);
    check("rst_errv", errv, 0);
    rst = 1'b0;
    tick();

    // Aligned word read at offset 4 with autoincrement
    sbaddress = 64'h1004; addr_wv = 1'b1; readonaddr = 1'b1; autoinc = 1'b1; sbaccess = 3'd2;
    tick(); addr_wv = 1'b0;
    check("rd_req", req, 1);
    check("rd_we", we, 0);
    check("rd_be", be, 8'hF0);
    check("rd_add", add, 64'h1004);
    gnt = 1'b1; tick(); gnt = 1'b0;
    check("rd_wait_req", req, 0);
    check("rd_wait_busy", busy, 1);
    r_valid = 1'b1; rdata = 64'hDEADBEEF_00000000; tick(); r_valid = 1'b0;
    check("rd_valid", sbdata_valid, 1);
    check("rd_data", sbdata, 64'hDEADBEEF);
    check("rd_incr", addr_o, 64'h1008);
    check("rd_idle", busy, 0);
    tick();
    check("rd_pulse", sbdata_valid, 0);

    // Byte write at offset 3
    autoinc = 1'b0; readonaddr = 1'b0;
    sbaddress = 64'h2003; addr_wv = 1'b1; tick(); addr_wv = 1'b0;
    check("wr_noreq", busy, 0);
    check("wr_addr", addr_o, 64'h2003);
    sbaccess = 3'd0; sbdata_in = 64'h55; data_wv = 1'b1; tick(); data_wv = 1'b0;
    check("wr_req", req, 1);
    check("wr_we", we, 1);
    check("wr_be", be, 8'h08);
    check("wr_wdata", wdata, 64'h55000000);
    gnt = 1'b1; tick(); gnt = 1'b0;
    check("wr_wait_busy", busy, 1);
    r_valid = 1'b1; tick(); r_valid = 1'b0;
    check("wr_done", busy, 0);
    check("wr_noincr", addr_o, 64'h2003);

    // Launch errors: misaligned halfword, then oversize (also misaligned)
    sbaccess = 3'd1; sbaddress = 64'h3001; readonaddr = 1'b1; addr_wv = 1'b1;
    tick(); addr_wv = 1'b0;
    check("mis_errv", errv, 1);
    check("mis_code", err, 3);
    check("mis_req", req, 0);
    check("mis_busy", busy, 0);
    check("mis_addr", addr_o, 64'h2003);
    tick();
    check("mis_pulse", errv, 0);
    sbaccess = 3'd4; readondata = 1'b1; data_rv = 1'b1; tick(); data_rv = 1'b0;
    readondata = 1'b0;
    check("size_errv", errv, 1);
    check("size_code", err, 4);
    check("size_busy", busy, 0);

    // Timeout with grant held low
    readonaddr = 1'b0; sbaccess = 3'd3; sbaddress = 64'h4000; addr_wv = 1'b1;
    tick(); addr_wv = 1'b0;
    readondata = 1'b1; data_rv = 1'b1; tick(); data_rv = 1'b0; readondata = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    check("to_hold_req", req, 1);
    check("to_hold_errv", errv, 0);
    tick();
    check("to_req", req, 0);
    check("to_errv", errv, 1);
    check("to_code", err, 1);
    check("to_addr", addr_o, 64'h4000);
    r_valid = 1'b1; rdata = 64'hFFFF; tick(); r_valid = 1'b0;
    check("to_late_valid", sbdata_valid, 0);
    check("to_late_busy", busy, 0);

    // Wrap to zero; grant and response together in READ do not complete the read
    sbaccess = 3'd2; autoinc = 1'b1; readonaddr = 1'b1;
    sbaddress = 64'hFFFF_FFFF_FFFF_FFFC; addr_wv = 1'b1; tick(); addr_wv = 1'b0;
    check("wrap_be", be, 8'hF0);
    gnt = 1'b1; r_valid = 1'b1; rdata = 64'h11111111_22222222; tick();
    gnt = 1'b0; r_valid = 1'b0;
    check("same_valid", sbdata_valid, 0);
    check("same_busy", busy, 1);
    r_valid = 1'b1; rdata = 64'h12345678_00000000; tick(); r_valid = 1'b0;
    check("wrap_valid", sbdata_valid, 1);
    check("wrap_data", sbdata, 64'h12345678);
    check("wrap_addr", addr_o, 64'h0);

    // 128-bit full-width read, timeout disabled
    sbaccess = 3'd4; w_sbaddress = 128'h100; w_addr_wv = 1'b1; tick(); w_addr_wv = 1'b0;
    check("w_req", w_req, 1);
    check("w_be", w_be, 16'hFFFF);
    for (int k = 0; k < 20; k++) tick();
    check("w_no_timeout", w_req, 1);
    check("w_no_err", w_errv, 0);
    w_gnt = 1'b1; tick(); w_gnt = 1'b0;
    w_r_valid = 1'b1; w_rdata = 128'h0123456789ABCDEF_FEDCBA9876543210; tick();
    w_r_valid = 1'b0;
    check("w_data", w_sbdata, 128'h0123456789ABCDEF_FEDCBA9876543210);
    check("w_incr", w_addr_o, 128'h110);

    // dmactive low during a write
    autoinc = 1'b0; readonaddr = 1'b0;
    sbaddress = 64'h5000; addr_wv = 1'b1; tick(); addr_wv = 1'b0;
    sbaccess = 3'd2; sbdata_in = 64'hCAFE; data_wv = 1'b1; tick(); data_wv = 1'b0;
    check("dm_we", we, 1);
    check("dm_wdata", wdata, 64'hCAFE);
    dmactive = 1'b0; tick();
    check("dm_busy", busy, 0);
    check("dm_req", req, 0);
    check("dm_errv", errv, 0);
    check("dm_addr", addr_o, 64'h5000);
    dmactive = 1'b1; tick();
    check("dm_errv2", errv, 0);

    // Asynchronous reset while waiting for a read response
    readonaddr = 1'b1; sbaddress = 64'h5000; addr_wv = 1'b1; tick(); addr_wv = 1'b0;
    gnt = 1'b1; tick(); gnt = 1'b0;
    check("ar_busy_pre", busy, 1);
    rst = 1'b1; #1;
    check("ar_busy", busy, 0);
    check("ar_req", req, 0);
    check("ar_addr", addr_o, 0);
    check("ar_sbdata", sbdata, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
